// File: rtl/board_mem_arbiter.sv
// Board-status RAM arbiter: VGA renderer has absolute priority, game writes are
// queued and drained in blanking, game reads run in blanking once the queue is empty.
// Optional stall statistics are enabled by defining BOARD_ARB_STATS_EN.
//
// state         | meaning
// RD_IDLE       | no game read outstanding
// RD_ISSUE      | RAM read issued last cycle, capture mem_dataOut now
// RD_CAPTURE    | gm_rdata valid, gm_rvalid pulses
module board_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vga_active,
    input  logic [ADDR_WIDTH-1:0]         vga_addr,
    output logic [DATA_WIDTH-1:0]         vga_data,
    input  logic                          gm_req,
    input  logic                          gm_we,
    input  logic [ADDR_WIDTH-1:0]         gm_addr,
    input  logic [DATA_WIDTH-1:0]         gm_wdata,
    output logic                          gm_ready,
    output logic                          gm_rvalid,
    output logic [DATA_WIDTH-1:0]         gm_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wEn,
    output logic [DATA_WIDTH-1:0]         mem_dataIn,
    input  logic [DATA_WIDTH-1:0]         mem_dataOut,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   stall_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ISSUE   = 2'd1,
        RD_CAPTURE = 2'd2
    } rd_state_t;

    rd_state_t rd_state_q, rd_state_d;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  vga_issued_q, vga_issued_d;
    logic [DATA_WIDTH-1:0] vga_data_q, vga_data_d;
    logic [DATA_WIDTH-1:0] gm_rdata_q, gm_rdata_d;

    logic empty, full, rd_pending, push_this_cycle;
    logic push, pop, rd_grant;

    always_comb begin
        empty           = (count_q == '0);
        full            = (count_q == CNT_W'(FIFO_DEPTH));
        rd_pending      = (rd_state_q != RD_IDLE);
        push_this_cycle = gm_req & gm_we & ~full;

        // Reads wait for an empty queue so they always see the latest write.
        if (gm_we) begin
            gm_ready = reset & ~full;
        end else begin
            gm_ready = reset & ~vga_active & empty & ~rd_pending & ~push_this_cycle;
        end

        push     = gm_req & gm_we & gm_ready;
        rd_grant = gm_req & ~gm_we & gm_ready;
        pop      = ~vga_active & ~empty;

        mem_addr     = vga_addr;
        mem_wEn      = 1'b0;
        mem_dataIn   = fifo_data_q[rd_ptr_q];
        vga_issued_d = 1'b1;
        if (vga_active) begin
            mem_addr = vga_addr;
        end else if (pop) begin
            mem_addr     = fifo_addr_q[rd_ptr_q];
            mem_wEn      = 1'b1;
            vga_issued_d = 1'b0;
        end else if (rd_grant) begin
            mem_addr     = gm_addr;
            vga_issued_d = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        vga_data_d = vga_issued_q ? mem_dataOut : vga_data_q;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        gm_rdata_d = gm_rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_grant) rd_state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
                // Data is already on its way back, so vga_active rising here is harmless.
                gm_rdata_d = mem_dataOut;
                rd_state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rd_state_d = RD_IDLE;
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q   <= RD_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            vga_issued_q <= 1'b0;
            vga_data_q   <= '0;
            gm_rdata_q   <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vga_issued_q <= vga_issued_d;
            vga_data_q   <= vga_data_d;
            gm_rdata_q   <= gm_rdata_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= gm_addr;
            fifo_data_q[wr_ptr_q] <= gm_wdata;
        end
    end

    assign vga_data   = vga_data_q;
    assign gm_rdata   = gm_rdata_q;
    assign gm_rvalid  = (rd_state_q == RD_CAPTURE);
    assign fifo_count = count_q;

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (gm_req && !gm_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural 1-cycle-latency board RAM.
module tb_board_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
`ifdef BOARD_ARB_STATS_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          vga_active;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          gm_req, gm_we;
    logic [AW-1:0] gm_addr;
    logic [DW-1:0] gm_wdata;
    logic          gm_ready, gm_rvalid;
    logic [DW-1:0] gm_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wEn;
    logic [DW-1:0] mem_dataIn;
    logic [DW-1:0] mem_dataOut;
    logic [3:0]    fifo_count;
    logic [15:0]   stall_count;

    logic [DW-1:0] ram [4096];
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    int rvalid_cnt = 0;
    int saved;

    board_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .vga_active(vga_active), .vga_addr(vga_addr),
        .vga_data(vga_data), .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr),
        .gm_wdata(gm_wdata), .gm_ready(gm_ready), .gm_rvalid(gm_rvalid),
        .gm_rdata(gm_rdata), .mem_addr(mem_addr), .mem_wEn(mem_wEn),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
        .fifo_count(fifo_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_dataOut <= ram[mem_addr];
        if (mem_wEn) ram[mem_addr] <= mem_dataIn;
        if (mem_wEn) wr_cnt <= wr_cnt + 1;
        if (mem_wEn && vga_active) bad_wr <= bad_wr + 1;
        if (gm_rvalid) rvalid_cnt <= rvalid_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + i;
        mem_dataOut = '0;
        reset = 1'b0; vga_active = 1'b0; vga_addr = '0;
        gm_req = 1'b1; gm_we = 1'b1; gm_addr = '0; gm_wdata = '0;
        tick(); tick();
        #1;
        chk("rst_ready", {31'b0, gm_ready}, 32'h0);
        chk("rst_vga_data", vga_data, 32'h0);
        chk("rst_gm_rdata", gm_rdata, 32'h0);
        chk("rst_rvalid", {31'b0, gm_rvalid}, 32'h0);
        chk("rst_fifo_count", {28'b0, fifo_count}, 32'h0);
        chk("rst_stall", {16'b0, stall_count}, 32'h0);
        gm_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // VGA streaming, 2-cycle latency
        vga_active = 1'b1;
        for (int i = 0; i <= 25; i++) begin
            vga_addr = AW'(i);
            tick();
            if (i >= 1) chk("vga_stream", vga_data, 32'hA000_0000 + (i - 1));
        end
        chk("vga_no_write", wr_cnt, 0);

        // Writes queued during active display
        for (int i = 0; i < 5; i++) begin
            gm_req = 1'b1; gm_we = 1'b1; gm_addr = AW'(3 + i); gm_wdata = 32'h9 + i;
            #1;
            chk("wr_active_ready", {31'b0, gm_ready}, 32'h1);
            tick();
        end
        gm_req = 1'b0;
        chk("wr_active_count", {28'b0, fifo_count}, 32'd5);
        chk("wr_active_noram", wr_cnt, 0);
        vga_active = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("drain_count", {28'b0, fifo_count}, i);
        end
        chk("drain_writes", wr_cnt, 5);
        chk("drain_ram3", ram[3], 32'h9);
        chk("drain_ram7", ram[7], 32'hD);

        // Fill to full, 9th write stalls
        vga_active = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gm_req = 1'b1; gm_we = 1'b1; gm_addr = AW'(16 + i); gm_wdata = 32'd100 + i;
            #1;
            chk("fill_ready", {31'b0, gm_ready}, 32'h1);
            tick();
        end
        gm_addr = AW'(30); gm_wdata = 32'hFFFF_0000;
        #1;
        chk("full_ready", {31'b0, gm_ready}, 32'h0);
        chk("full_count", {28'b0, fifo_count}, 32'd8);
        tick(); tick(); tick();
        chk("full_stall", {16'b0, stall_count}, EXP_STALL);
        chk("full_held", {28'b0, fifo_count}, 32'd8);
        gm_req = 1'b0;
        vga_active = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full_drained", {28'b0, fifo_count}, 32'd0);
        chk("full_writes", wr_cnt, 13);
        chk("full_ram23", ram[23], 32'd107);
        chk("full_ram30", ram[30], 32'hA000_001E);

        // Read-after-write ordering in blanking
        gm_req = 1'b1; gm_we = 1'b1; gm_addr = AW'(7); gm_wdata = 32'h2;
        #1;
        chk("raw_wr_ready", {31'b0, gm_ready}, 32'h1);
        tick();
        gm_we = 1'b0;
        #1;
        chk("raw_rd_blocked", {31'b0, gm_ready}, 32'h0);
        tick();
        #1;
        chk("raw_rd_granted", {31'b0, gm_ready}, 32'h1);
        tick();
        gm_req = 1'b0;
        chk("raw_rvalid_n1", {31'b0, gm_rvalid}, 32'h0);
        tick();
        chk("raw_rvalid_n2", {31'b0, gm_rvalid}, 32'h1);
        chk("raw_rdata", gm_rdata, 32'h2);
        tick();
        chk("raw_rvalid_n3", {31'b0, gm_rvalid}, 32'h0);

        // Read granted, then display becomes active next cycle
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = AW'(20);
        #1;
        chk("rdact_ready", {31'b0, gm_ready}, 32'h1);
        tick();
        gm_req = 1'b0; vga_active = 1'b1; vga_addr = AW'(5);
        chk("rdact_rvalid_n1", {31'b0, gm_rvalid}, 32'h0);
        tick();
        vga_addr = AW'(6);
        chk("rdact_rvalid_n2", {31'b0, gm_rvalid}, 32'h1);
        chk("rdact_rdata", gm_rdata, 32'd104);
        tick();
        vga_addr = AW'(7);
        chk("rdact_vga5", vga_data, 32'hB);
        tick();
        chk("rdact_vga6", vga_data, 32'hC);
        tick();
        chk("rdact_vga7", vga_data, 32'h2);

        // Reset with three queued writes
        for (int i = 0; i < 3; i++) begin
            gm_req = 1'b1; gm_we = 1'b1; gm_addr = AW'(50 + i); gm_wdata = 32'hBAD0 + i;
            tick();
        end
        chk("rstq_count_pre", {28'b0, fifo_count}, 32'd3);
        reset = 1'b0;
        #1;
        chk("rstq_count", {28'b0, fifo_count}, 32'd0);
        chk("rstq_ready", {31'b0, gm_ready}, 32'h0);
        chk("rstq_vga_data", vga_data, 32'h0);
        chk("rstq_gm_rdata", gm_rdata, 32'h0);
        chk("rstq_stall", {16'b0, stall_count}, 32'h0);
        gm_req = 1'b0;
        tick();
        reset = 1'b1; vga_active = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rstq_no_stale", wr_cnt, 14);
        chk("rstq_ram50", ram[50], 32'hA000_0032);

        // Reset while a read is in flight
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = AW'(20);
        #1;
        chk("rstrd_ready", {31'b0, gm_ready}, 32'h1);
        tick();
        gm_req = 1'b0;
        saved = rvalid_cnt;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rstrd_no_rvalid", rvalid_cnt, saved);
        chk("rstrd_rdata", gm_rdata, 32'h0);
        chk("no_write_in_active", bad_wr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
